// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and counter sizing.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // The wait counter must hold WaitStates itself and is never narrower than one bit.
  function automatic int cnt_width(input int ws);
    return (ws > 0) ? $clog2(ws + 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM, no reset; accesses only when en is high.
// Latency: read data registered one edge after en; write commits on the same edge.
// Backpressure: none, the owner sequences all accesses.
module dmem_array #(
  parameter int AddrW    = 8,
  parameter int DataSize = 32,
  parameter int Depth    = 200
) (
  input  logic                clk_i,
  input  logic                en,
  input  logic                we,
  input  logic [AddrW-1:0]    addr,
  input  logic [DataSize-1:0] wdata,
  output logic [DataSize-1:0] rdata
);

  logic [DataSize-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one word read/write per valid/ready request, response after wait states.
// Latency: accept at edge N gives rsp_valid_o after edge N+1+WaitStates; idle cycle between transactions.
// Backpressure: rsp_ready_i low holds the response and blocks new requests indefinitely.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int AddrSize   = 8,
  parameter int DataSize   = 32,
  parameter int Depth      = 200,
  parameter int WaitStates = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [AddrSize-1:0] req_addr_i,
  input  logic [DataSize-1:0] req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DataSize-1:0] rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                busy_o
);

  localparam int CntW  = cnt_width(WaitStates);
  localparam int MemAw = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrSize:0] DepthW = (AddrSize + 1)'(Depth);

  dmem_state_e         state_q;
  logic [CntW-1:0]     cnt_q;
  logic                we_q;
  logic [AddrSize-1:0] addr_q;
  logic [DataSize-1:0] wdata_q;
  logic                rd_sel_q;
  logic [DataSize-1:0] ram_rdata;
  logic                req_fire;
  logic                rsp_fire;
  logic                in_range;
  logic                commit;

  assign req_fire = req_valid_i && req_ready_o;
  assign rsp_fire = rsp_valid_o && rsp_ready_i;
  assign in_range = {1'b0, addr_q} < DepthW;
  // The last wait cycle performs the array access, so the response lands on the RESP entry edge.
  assign commit   = (state_q == DMEM_WAIT) && (cnt_q == '0);

  dmem_array #(
    .AddrW    (MemAw),
    .DataSize (DataSize),
    .Depth    (Depth)
  ) u_array (
    .clk_i (clk_i),
    .en    (commit && in_range),
    .we    (we_q),
    .addr  (addr_q[MemAw-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The RAM output register holds the read word through RESP; writes and errors mask it to zero.
  assign rsp_rdata_o = rd_sel_q ? ram_rdata : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_sel_q    <= 1'b0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          req_ready_o <= 1'b1;
          if (req_fire) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            cnt_q       <= CntW'(WaitStates);
            state_q     <= DMEM_WAIT;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        DMEM_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= DMEM_RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= !in_range;
            rd_sel_q    <= in_range && !we_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DMEM_RESP: begin
          if (rsp_fire) begin
            state_q     <= DMEM_IDLE;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rd_sel_q    <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: state_q <= DMEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: WaitStates=2 and WaitStates=0 instances, directed vectors.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  rsp_t q_a[$];
  rsp_t q_b[$];
  rsp_t exp_a, exp_b;

  logic        a_req_valid, a_req_ready, a_we, a_rsp_valid, a_rsp_ready, a_err, a_busy;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req_valid, b_req_ready, b_we, b_rsp_valid, b_rsp_ready, b_err, b_busy;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;

  dmem_responder #(.AddrSize(8), .DataSize(32), .Depth(200), .WaitStates(2)) u_a (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
    .req_we_i(a_we), .req_addr_i(a_addr), .req_wdata_i(a_wdata), .rsp_valid_o(a_rsp_valid),
    .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rdata), .rsp_err_o(a_err), .busy_o(a_busy)
  );

  dmem_responder #(.AddrSize(8), .DataSize(32), .Depth(200), .WaitStates(0)) u_b (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_we_i(b_we), .req_addr_i(b_addr), .req_wdata_i(b_wdata), .rsp_valid_o(b_rsp_valid),
    .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rdata), .rsp_err_o(b_err), .busy_o(b_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Latency monitors: accept edge number vs. edge on which rsp_valid first appears.
  int   a_acc = 0, b_acc = 0;
  logic a_prev = 1'b0, b_prev = 1'b0;
  always @(posedge clk) begin
    if (a_req_valid && a_req_ready) a_acc = cyc + 1;
    if (b_req_valid && b_req_ready) b_acc = cyc + 1;
  end

  // Response scoreboards: compare on every response handshake.
  always @(negedge clk) begin
    if (a_rsp_valid && !a_prev) check("a_latency", cyc - a_acc, 3);
    a_prev = a_rsp_valid;
    if (a_rsp_valid && a_rsp_ready) begin
      if (q_a.size() == 0) begin
        timeout("a_unexpected_rsp");
      end else begin
        exp_a = q_a.pop_front();
        check("a_rdata", a_rdata, exp_a.rdata);
        check("a_err", a_err, exp_a.err);
      end
    end
    if (b_rsp_valid && !b_prev) check("b_latency", cyc - b_acc, 1);
    b_prev = b_rsp_valid;
    if (b_rsp_valid && b_rsp_ready) begin
      if (q_b.size() == 0) begin
        timeout("b_unexpected_rsp");
      end else begin
        exp_b = q_b.pop_front();
        check("b_rdata", b_rdata, exp_b.rdata);
        check("b_err", b_err, exp_b.err);
      end
    end
  end

  task automatic a_send(input logic we, input logic [7:0] addr, input logic [31:0] wd);
    @(negedge clk);
    a_we = we; a_addr = addr; a_wdata = wd; a_req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (a_req_ready) begin
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    a_req_valid = 1'b0;
    timeout("a_accept");
  endtask

  task automatic a_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!a_busy) return;
    end
    timeout("a_done");
  endtask

  task automatic a_txn(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err);
    q_a.push_back('{rdata: rd, err: err});
    a_send(we, addr, wd);
    a_done();
  endtask

  task automatic b_send(input logic we, input logic [7:0] addr, input logic [31:0] wd);
    @(negedge clk);
    b_we = we; b_addr = addr; b_wdata = wd; b_req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (b_req_ready) begin
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    timeout("b_accept");
  endtask

  task automatic b_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!b_busy) return;
    end
    timeout("b_done");
  endtask

  task automatic b_txn(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err);
    q_b.push_back('{rdata: rd, err: err});
    b_send(we, addr, wd);
    b_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int acc1, acc2;
  bit seen;

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", a_req_ready, 0);
    check("rst_a_valid", a_rsp_valid, 0);
    check("rst_a_err", a_err, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_ready", b_req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_a_ready", a_req_ready, 1);
    check("post_rst_b_ready", b_req_ready, 1);

    // Write/read and address-range boundaries on the WaitStates=2 instance.
    a_txn(1'b1, 8'h05, 32'hDEADBEEF, 32'h0, 1'b0);
    a_txn(1'b0, 8'h05, 32'h0, 32'hDEADBEEF, 1'b0);
    a_txn(1'b1, 8'h00, 32'h0BADF00D, 32'h0, 1'b0);
    a_txn(1'b0, 8'hC8, 32'h0, 32'h0, 1'b1);
    a_txn(1'b1, 8'hC8, 32'h55555555, 32'h0, 1'b1);
    a_txn(1'b0, 8'h00, 32'h0, 32'h0BADF00D, 1'b0);
    a_txn(1'b0, 8'hFF, 32'h0, 32'h0, 1'b1);
    a_txn(1'b1, 8'hC7, 32'hC0FFEE00, 32'h0, 1'b0);
    a_txn(1'b0, 8'hC7, 32'h0, 32'hC0FFEE00, 1'b0);

    // Response backpressure with a competing request held on the request port.
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    q_a.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    a_send(1'b0, 8'h05, 32'h0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (a_rsp_valid) seen = 1;
    end
    if (!seen) timeout("bp_valid");
    a_we = 1'b1; a_addr = 8'h06; a_wdata = 32'h66666666; a_req_valid = 1'b1;
    q_a.push_back('{rdata: 32'h0, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", a_rsp_valid, 1);
      check("bp_rdata_held", a_rdata, 32'hDEADBEEF);
      check("bp_ready_low", a_req_ready, 0);
    end
    @(posedge clk); #1;
    a_rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (a_req_ready) seen = 1;
    end
    if (!seen) timeout("bp_accept");
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    a_done();
    a_txn(1'b0, 8'h06, 32'h0, 32'h66666666, 1'b0);

    // Reset while a write is still waiting: the write must be lost.
    a_txn(1'b1, 8'h10, 32'hAAAAAAAA, 32'h0, 1'b0);
    a_send(1'b1, 8'h10, 32'h12345678);
    @(negedge clk);
    check("midwr_busy", a_busy, 1);
    check("midwr_valid", a_rsp_valid, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", a_req_ready, 0);
    check("midrst_valid", a_rsp_valid, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_err", a_err, 0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready_after", a_req_ready, 1);
    a_txn(1'b0, 8'h10, 32'h0, 32'hAAAAAAAA, 1'b0);

    // Zero-wait instance: back-to-back reads are accepted three cycles apart.
    b_txn(1'b1, 8'h01, 32'h11111111, 32'h0, 1'b0);
    b_txn(1'b1, 8'h02, 32'h22222222, 32'h0, 1'b0);
    q_b.push_back('{rdata: 32'h11111111, err: 1'b0});
    q_b.push_back('{rdata: 32'h22222222, err: 1'b0});
    b_send(1'b0, 8'h01, 32'h0);
    acc1 = cyc;
    b_send(1'b0, 8'h02, 32'h0);
    acc2 = cyc;
    check("b_accept_spacing", acc2 - acc1, 3);
    b_done();
    b_txn(1'b0, 8'hC8, 32'h0, 32'h0, 1'b1);

    repeat (3) @(negedge clk);
    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
